// File: rtl/proc_pkg.sv
// proc_pkg: processor-wide constants shared by the register file and the control unit.
// Holds datapath width, register count, instruction field positions and opcodes.
package proc_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int ADDR_W = 4;

  // Instruction layout: rs | rt | rd | opcode
  localparam int RS_HI = 15;
  localparam int RS_LO = 12;
  localparam int RT_HI = 11;
  localparam int RT_LO = 8;
  localparam int RD_HI = 7;
  localparam int RD_LO = 4;
  localparam int OP_HI = 3;
  localparam int OP_LO = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_LW   = 4'h8,
    OP_SW   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_ADDI = 4'hB
  } opcode_t;

  function automatic logic [ADDR_W-1:0] field_rs(input logic [15:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [ADDR_W-1:0] field_rt(input logic [15:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

  function automatic logic [ADDR_W-1:0] field_rd(input logic [15:0] instr);
    return instr[RD_HI:RD_LO];
  endfunction

endpackage

// File: rtl/reg_array.sv
// reg_array: architectural register storage.
// Two combinational read ports, one debug read port, one synchronous write port.
// r0 is hardwired to zero; the whole array clears asynchronously while reset is low.
module reg_array
  import proc_pkg::*;
#(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int NREGS  = proc_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        raddr_a,
  input  logic [3:0]        raddr_b,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  // Storage update: async clear, otherwise write any register except r0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 4'd0) && (int'(waddr) < NREGS)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: r0 and out-of-range addresses return zero
  always_comb begin
    rdata_a  = '0;
    rdata_b  = '0;
    dbg_data = '0;
    if ((raddr_a != 4'd0) && (int'(raddr_a) < NREGS)) rdata_a = regs[raddr_a];
    if ((raddr_b != 4'd0) && (int'(raddr_b) < NREGS)) rdata_b = regs[raddr_b];
    if ((dbg_addr != 4'd0) && (int'(dbg_addr) < NREGS)) dbg_data = regs[dbg_addr];
  end

endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: register file with a one-entry write-back pending stage.
// A write is captured on one edge and committed to reg_array on the next.
// Optional macro REGFILE_BYPASS_EN forwards the pending value to rs/rt reads;
// without it, reads see only the committed array.
module reg_file_wb
  import proc_pkg::*;
#(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int NREGS  = proc_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              regdest,
  input  logic              regwrite,
  input  logic              memtoreg,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stall,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_pending,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  logic [3:0]        rs_addr;
  logic [3:0]        rt_addr;
  logic [3:0]        wb_addr;
  logic [DATA_W-1:0] wb_value;
  logic              capture;
  logic [3:0]        pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic [DATA_W-1:0] arr_rs;
  logic [DATA_W-1:0] arr_rt;
  logic              unused_opcode;

  assign rs_addr       = field_rs(instr);
  assign rt_addr       = field_rt(instr);
  assign unused_opcode = ^instr[OP_HI:OP_LO];

  // Write-back source/destination muxes and capture qualification (r0 writes dropped)
  always_comb begin
    wb_value = memtoreg ? mem_rdata : alu_result;
    wb_addr  = regdest ? field_rd(instr) : field_rt(instr);
    capture  = regwrite && !stall && (wb_addr != 4'd0);
  end

  // Pending stage and commit counter; a pending write always commits on the next edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_addr  <= '0;
      pend_data  <= '0;
      wb_pending <= 1'b0;
      wr_count   <= '0;
    end else begin
      wb_pending <= capture;
      if (capture) begin
        pend_addr <= wb_addr;
        pend_data <= wb_value;
      end
      if (wb_pending && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  reg_array #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_reg_array (
    .clk      (clk),
    .reset    (reset),
    .we       (wb_pending),
    .waddr    (pend_addr),
    .wdata    (pend_data),
    .raddr_a  (rs_addr),
    .raddr_b  (rt_addr),
    .dbg_addr (dbg_addr),
    .rdata_a  (arr_rs),
    .rdata_b  (arr_rt),
    .dbg_data (dbg_data)
  );

`ifdef REGFILE_BYPASS_EN
  // Read ports forward the not-yet-committed value when addresses match
  always_comb begin
    rs_data = arr_rs;
    rt_data = arr_rt;
    if (wb_pending && (pend_addr != 4'd0) && (pend_addr == rs_addr)) rs_data = pend_data;
    if (wb_pending && (pend_addr != 4'd0) && (pend_addr == rt_addr)) rt_data = pend_data;
  end
`else
  // Read ports return committed array contents only
  always_comb begin
    rs_data = arr_rs;
    rt_data = arr_rt;
  end
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed scenarios plus randomized traffic for reg_file_wb,
// checked against a queue-based reference model of the write-back behaviour.
module tb_reg_file_wb;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        regdest;
  logic        regwrite;
  logic        memtoreg;
  logic [15:0] alu_result;
  logic [15:0] mem_rdata;
  logic        stall;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic        wb_pending;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] wr_count;

  int checks_total;
  int checks_passed;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] model_regs [16];
  wr_t         pending_q [$];
  int          model_count;

  reg_file_wb dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .regdest    (regdest),
    .regwrite   (regwrite),
    .memtoreg   (memtoreg),
    .alu_result (alu_result),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .wb_pending (wb_pending),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .wr_count   (wr_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk_instr(input logic [3:0] rs, input logic [3:0] rt,
                                           input logic [3:0] rd, input logic [3:0] op);
    return {rs, rt, rd, op};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_regs[i] = 16'h0000;
    pending_q.delete();
    model_count = 0;
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (pending_q.size() > 0 && pending_q[0].addr == a) return pending_q[0].data;
`endif
    return model_regs[a];
  endfunction

  // One cycle: drive at the falling edge, check 1ns later, advance model at the rising edge
  task automatic apply_stimulus(input logic rst_v, input logic [15:0] ins, input logic rw,
                                input logic rdsel, input logic m2r, input logic stl,
                                input logic [15:0] alu, input logic [15:0] mem,
                                input logic [3:0] dbg);
    logic [3:0]  dest;
    logic [15:0] val;
    wr_t         w;
    reset      = rst_v;
    instr      = ins;
    regwrite   = rw;
    regdest    = rdsel;
    memtoreg   = m2r;
    stall      = stl;
    alu_result = alu;
    mem_rdata  = mem;
    dbg_addr   = dbg;
    if (!rst_v) model_clear();
    #1;
    check_output("rs_data",    32'(rs_data),    32'(model_read(ins[15:12])));
    check_output("rt_data",    32'(rt_data),    32'(model_read(ins[11:8])));
    check_output("dbg_data",   32'(dbg_data),   32'(dbg == 4'd0 ? 16'h0000 : model_regs[dbg]));
    check_output("wb_pending", 32'(wb_pending), 32'(pending_q.size() != 0));
    check_output("wr_count",   32'(wr_count),   32'(model_count));
    @(posedge clk);
    if (rst_v) begin
      if (pending_q.size() > 0) begin
        w = pending_q.pop_front();
        model_regs[w.addr] = w.data;
        if (model_count < 65535) model_count++;
      end
      dest = rdsel ? ins[7:4] : ins[11:8];
      val  = m2r ? mem : alu;
      if (rw && !stl && dest != 4'd0) begin
        w.addr = dest;
        w.data = val;
        pending_q.push_back(w);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [15:0] ins, input logic [3:0] dbg);
    apply_stimulus(1'b1, ins, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, dbg);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    model_clear();
    reset = 1'b0; instr = '0; regwrite = 0; regdest = 0; memtoreg = 0;
    stall = 0; alu_result = '0; mem_rdata = '0; dbg_addr = '0;
    @(negedge clk);
    apply_stimulus(1'b0, 16'h3456, 1'b1, 1'b1, 1'b0, 1'b0, 16'hAAAA, 16'h5555, 4'd3);
    apply_stimulus(1'b0, 16'h3456, 1'b1, 1'b1, 1'b0, 1'b0, 16'hAAAA, 16'h5555, 4'd3);
    check_output("reset_count", 32'(wr_count), 32'd0);

    // Write r3 = 0x1234 via rd, captured on the first edge after reset release
    apply_stimulus(1'b1, mk_instr(4'd0, 4'd0, 4'd3, 4'h0), 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 4'd3);
    check_output("r3_pending", 32'(wb_pending), 32'd1);
    idle(16'h0000, 4'd3);
    check_output("r3_dbg",     32'(dbg_data),   32'h1234);
    check_output("r3_count",   32'(wr_count),   32'd1);
    check_output("r3_pend_clr", 32'(wb_pending), 32'd0);

    // Write r5 from memory via rt, then read it immediately through rs
    apply_stimulus(1'b1, mk_instr(4'd0, 4'd5, 4'd0, 4'h8), 1'b1, 1'b0, 1'b1, 1'b0, 16'h1111, 16'hBEEF, 4'd0);
    idle(mk_instr(4'd5, 4'd3, 4'd0, 4'h0), 4'd5);
    idle(mk_instr(4'd5, 4'd0, 4'd0, 4'h0), 4'd5);
    check_output("r5_committed", 32'(rs_data), 32'hBEEF);

    // Write to r0 is dropped entirely
    apply_stimulus(1'b1, mk_instr(4'd0, 4'd0, 4'd0, 4'h0), 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 4'd0);
    check_output("r0_pending", 32'(wb_pending), 32'd0);
    check_output("r0_count",   32'(wr_count),   32'd2);
    idle(16'h0000, 4'd0);
    check_output("r0_read",    32'(rs_data),    32'd0);

    // Back-to-back writes to r2, newer value wins
    apply_stimulus(1'b1, mk_instr(4'd0, 4'd0, 4'd2, 4'h0), 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000, 4'd2);
    apply_stimulus(1'b1, mk_instr(4'd0, 4'd0, 4'd2, 4'h0), 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000, 4'd2);
    idle(mk_instr(4'd2, 4'd0, 4'd0, 4'h0), 4'd2);
    check_output("r2_value", 32'(dbg_data), 32'h0002);
    check_output("r2_count", 32'(wr_count), 32'd4);

    // Capture r7, then a stalled write to r8 is ignored while r7 still commits
    apply_stimulus(1'b1, mk_instr(4'd0, 4'd0, 4'd7, 4'h0), 1'b1, 1'b1, 1'b0, 1'b0, 16'h00AA, 16'h0000, 4'd7);
    apply_stimulus(1'b1, mk_instr(4'd0, 4'd0, 4'd8, 4'h0), 1'b1, 1'b1, 1'b0, 1'b1, 16'h0BBB, 16'h0000, 4'd7);
    check_output("stall_pending", 32'(wb_pending), 32'd0);
    check_output("r7_value",      32'(dbg_data),   32'h00AA);
    idle(16'h0000, 4'd8);
    check_output("r8_untouched",  32'(dbg_data),   32'h0000);

    // Capture r4, then reset before the commit edge discards it
    apply_stimulus(1'b1, mk_instr(4'd0, 4'd0, 4'd4, 4'h0), 1'b1, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h0000, 4'd4);
    apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd4);
    idle(mk_instr(4'd4, 4'd7, 4'd0, 4'h0), 4'd4);
    check_output("r4_discarded", 32'(dbg_data), 32'h0000);
    check_output("r4_count",     32'(wr_count), 32'd0);

    // Randomized traffic with occasional resets and stalls
    for (int n = 0; n < 400; n++) begin
      apply_stimulus(($urandom_range(0, 99) != 0),
                     16'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                     1'($urandom), ($urandom_range(0, 3) == 0),
                     16'($urandom), 16'($urandom), 4'($urandom));
    end

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
